// File: rtl/ber_align_counter_pkg.sv
// Shared types and constants for the BER alignment counter.
// State encoding plus PRBS9-based default sizing.
package ber_align_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_SEARCH = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   localparam int PRBS9_PERIOD = 511;
   localparam int DEF_DEPTH    = 512;
   localparam int DEF_WINDOW   = PRBS9_PERIOD;

endpackage

// File: rtl/ber_align_counter_ref_delay_line.sv
// Reference PRBS history with a selectable tap.
// Tap 0 is the current input bit; tap d is the bit from d strobes ago.
module ref_delay_line #(
   parameter int DEPTH    = 512,
   parameter int NB_DELAY = 9
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic                i_bit,
   input  logic [NB_DELAY-1:0] i_sel,
   output logic                o_ref
);

   logic [DEPTH-2:0] hist_q;
   logic [DEPTH-2:0] hist_d;
   logic [DEPTH-1:0] taps;

   always_comb begin
      hist_d = hist_q;
      if (i_valid) hist_d = {hist_q[DEPTH-3:0], i_bit};
      taps  = {hist_q, i_bit};
      o_ref = taps[i_sel];
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) hist_q <= '0;
      else          hist_q <= hist_d;
   end

endmodule

// File: rtl/ber_align_counter.sv
// BER checker: sweeps reference delays for the best match, then
// locks and accumulates saturating bit/error counts.
module ber_align_counter
   import ber_align_counter_pkg::*;
#(
   parameter int NB_COUNT = 64,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NB_DELAY = 9,
   parameter int WINDOW   = DEF_WINDOW,
   parameter int NB_WIN   = 9
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_valid,
   input  logic                i_slicer,
   input  logic                i_prbs,
   output logic                o_exor,
   output logic [NB_COUNT-1:0] o_counter_bit,
   output logic [NB_COUNT-1:0] o_counter_err,
   output logic [NB_DELAY-1:0] o_delay,
   output logic                o_locked,
   output logic                o_busy
);

   state_t state_q, state_d;
   logic en_q;
   logic rise;
   logic [NB_DELAY-1:0] fill_q, fill_d;
   logic [NB_DELAY-1:0] d_q, d_d;
   logic [NB_DELAY-1:0] best_q, best_d;
   logic [NB_DELAY-1:0] delay_q, delay_d;
   logic [NB_WIN-1:0] win_cnt_q, win_cnt_d;
   logic [NB_WIN-1:0] win_err_q, win_err_d;
   logic [NB_WIN-1:0] min_q, min_d;
   logic [NB_WIN-1:0] werr;
   logic [NB_COUNT-1:0] cbit_q, cbit_d;
   logic [NB_COUNT-1:0] cerr_q, cerr_d;
   logic exor_q, exor_d;
   logic locked_q, busy_q;
   logic [NB_DELAY-1:0] sel;
   logic ref_bit;
   logic err_bit;
   logic win_end;

   assign rise = i_enable & ~en_q;
   assign sel  = (state_q == ST_LOCK) ? delay_q : d_q;

   ref_delay_line #(
      .DEPTH    (DEPTH),
      .NB_DELAY (NB_DELAY)
   ) u_ref (
      .clock   (clock),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .i_bit   (i_prbs),
      .i_sel   (sel),
      .o_ref   (ref_bit)
   );

   assign err_bit = i_slicer ^ ref_bit;
   assign werr    = win_err_q + NB_WIN'(err_bit);
   assign win_end = (win_cnt_q == NB_WIN'(WINDOW - 1));

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      d_d       = d_q;
      best_d    = best_q;
      delay_d   = delay_q;
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      min_d     = min_q;
      cbit_d    = cbit_q;
      cerr_d    = cerr_q;
      exor_d    = 1'b0;
      if (state_q == ST_SEARCH || state_q == ST_LOCK)
         exor_d = i_valid ? err_bit : exor_q;
      // Enable loss wins over any window end on the same clock.
      if (!i_enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_FILL;
                  fill_d  = '0;
                  cbit_d  = '0;
                  cerr_d  = '0;
                  delay_d = '0;
               end
            end
            ST_FILL: begin
               if (i_valid) begin
                  if (fill_q == NB_DELAY'(DEPTH - 2)) begin
                     state_d   = ST_SEARCH;
                     d_d       = '0;
                     win_cnt_d = '0;
                     win_err_d = '0;
                     min_d     = '1;
                     best_d    = '0;
                  end else begin
                     fill_d = fill_q + 1'b1;
                  end
               end
            end
            ST_SEARCH: begin
               if (i_valid) begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  win_err_d = werr;
                  if (win_end) begin
                     win_cnt_d = '0;
                     win_err_d = '0;
                     if (werr == '0) begin
                        delay_d = d_q;
                        state_d = ST_LOCK;
                     end else begin
                        if (werr < min_q) begin
                           min_d  = werr;
                           best_d = d_q;
                        end
                        if (d_q == '1) begin
                           delay_d = (werr < min_q) ? d_q : best_q;
                           state_d = ST_LOCK;
                        end else begin
                           d_d = d_q + 1'b1;
                        end
                     end
                  end
               end
            end
            ST_LOCK: begin
               if (i_valid) begin
                  if (cbit_q != '1) cbit_d = cbit_q + 1'b1;
                  if (err_bit && cerr_q != '1) cerr_d = cerr_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         fill_q    <= '0;
         d_q       <= '0;
         best_q    <= '0;
         delay_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         min_q     <= '0;
         cbit_q    <= '0;
         cerr_q    <= '0;
         exor_q    <= 1'b0;
         locked_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= i_enable;
         fill_q    <= fill_d;
         d_q       <= d_d;
         best_q    <= best_d;
         delay_q   <= delay_d;
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
         min_q     <= min_d;
         cbit_q    <= cbit_d;
         cerr_q    <= cerr_d;
         exor_q    <= exor_d;
         locked_q  <= (state_d == ST_LOCK);
         busy_q    <= (state_d == ST_FILL) || (state_d == ST_SEARCH);
      end
   end

   assign o_exor        = exor_q;
   assign o_counter_bit = cbit_q;
   assign o_counter_err = cerr_q;
   assign o_delay       = delay_q;
   assign o_locked      = locked_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_ber_align_counter.sv
// Directed bench for ber_align_counter, scaled to DEPTH=16 with a PRBS4
// reference so one window is exactly one sequence period.
module tb_ber_align_counter;

   localparam int DEPTH  = 16;
   localparam int NBD    = 4;
   localparam int WINDOW = 15;
   localparam int NBW    = 4;

   logic clock = 1'b0;
   logic i_reset, i_enable, i_valid, i_slicer, i_prbs;
   logic o_exor, o_locked, o_busy;
   logic [15:0] o_counter_bit, o_counter_err;
   logic [NBD-1:0] o_delay;
   logic s_exor, s_locked, s_busy;
   logic [3:0] s_counter_bit, s_counter_err;
   logic [NBD-1:0] s_delay;

   always #5 clock = ~clock;

   ber_align_counter #(
      .NB_COUNT (16), .DEPTH (DEPTH), .NB_DELAY (NBD),
      .WINDOW (WINDOW), .NB_WIN (NBW)
   ) dut (
      .clock (clock), .i_reset (i_reset), .i_enable (i_enable),
      .i_valid (i_valid), .i_slicer (i_slicer), .i_prbs (i_prbs),
      .o_exor (o_exor), .o_counter_bit (o_counter_bit),
      .o_counter_err (o_counter_err), .o_delay (o_delay),
      .o_locked (o_locked), .o_busy (o_busy)
   );

   ber_align_counter #(
      .NB_COUNT (4), .DEPTH (DEPTH), .NB_DELAY (NBD),
      .WINDOW (WINDOW), .NB_WIN (NBW)
   ) dut_s (
      .clock (clock), .i_reset (i_reset), .i_enable (i_enable),
      .i_valid (i_valid), .i_slicer (i_slicer), .i_prbs (i_prbs),
      .o_exor (s_exor), .o_counter_bit (s_counter_bit),
      .o_counter_err (s_counter_err), .o_delay (s_delay),
      .o_locked (s_locked), .o_busy (s_busy)
   );

   int checks = 0;
   int failures = 0;
   logic [3:0] lfsr = 4'b0001;
   bit h [32];
   int k_dly = 0;
   bit force_err = 0;
   bit const_mode = 0;
   int sidx = 0;
   int nforced = 0;
   logic sb [$];
   int n;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One symbol strobe followed by three idle clocks.
   task automatic strobe(input bit chk);
      bit p, s, f;
      logic e;
      if (const_mode) p = 1'b0;
      else begin
         p = lfsr[3];
         lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end
      for (int i = 31; i > 0; i--) h[i] = h[i-1];
      h[0] = p;
      f = force_err && (sidx % 15 == 0);
      s = const_mode ? 1'b1 : (h[k_dly] ^ f);
      sidx++;
      if (chk) begin
         sb.push_back(s ^ h[k_dly]);
         if (f) nforced++;
      end
      i_prbs = p;
      i_slicer = s;
      i_valid = 1'b1;
      @(posedge clock); #1;
      i_valid = 1'b0;
      if (chk) begin
         e = sb.pop_front();
         check("exor", o_exor, e);
      end
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic run_chk(input int cnt);
      for (int i = 0; i < cnt; i++) strobe(1);
   endtask

   task automatic wait_lock(output int cnt);
      cnt = 0;
      while (!o_locked && cnt < 400) begin
         strobe(0);
         cnt++;
      end
   endtask

   task automatic restart();
      i_enable = 1'b0;
      @(posedge clock); #1;
      i_enable = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      i_reset = 1'b0;
      i_enable = 1'b0;
      i_valid = 1'b0;
      i_slicer = 1'b0;
      i_prbs = 1'b0;
      for (int i = 0; i < 32; i++) h[i] = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_locked", o_locked, 0);
      check("rst_busy", o_busy, 0);
      check("rst_delay", o_delay, 0);
      check("rst_bits", o_counter_bit, 0);
      check("rst_errs", o_counter_err, 0);
      check("rst_exor", o_exor, 0);
      i_reset = 1'b1;
      @(posedge clock); #1;

      // Clean link, reference delayed by 5.
      k_dly = 5;
      i_enable = 1'b1;
      @(posedge clock); #1;
      check("t1_busy", o_busy, 1);
      wait_lock(n);
      check("t1_lock_strobes", n, 15 + 6 * 15);
      check("t1_delay", o_delay, 5);
      run_chk(20);
      check("t1_bits", o_counter_bit, 20);
      check("t1_errs", o_counter_err, 0);
      check("t1_sat_bits", s_counter_bit, 15);
      check("t1_sat_errs", s_counter_err, 0);

      // Enable dropped while locked.
      i_enable = 1'b0;
      for (int i = 0; i < 10; i++) strobe(0);
      check("t4_locked", o_locked, 0);
      check("t4_busy", o_busy, 0);
      check("t4_bits_frozen", o_counter_bit, 20);
      check("t4_delay_frozen", o_delay, 5);
      check("t4_exor", o_exor, 0);
      i_enable = 1'b1;
      @(posedge clock); #1;
      check("t4_bits_clr", o_counter_bit, 0);
      check("t4_delay_clr", o_delay, 0);
      check("t4_busy_fill", o_busy, 1);
      wait_lock(n);
      check("t4_lock_strobes", n, 15 + 6 * 15);
      check("t4_delay", o_delay, 5);

      // One forced error per period: full sweep, best is delay 10.
      k_dly = 10;
      force_err = 1;
      restart();
      wait_lock(n);
      check("t2_lock_strobes", n, 15 + 16 * 15);
      check("t2_delay", o_delay, 10);
      nforced = 0;
      run_chk(30);
      check("t2_bits", o_counter_bit, 30);
      check("t2_errs", o_counter_err, nforced);
      check("t2_nforced", nforced, 2);
      check("t2_sat_bits", s_counter_bit, 15);
      check("t2_sat_errs", s_counter_err, 2);

      // Every window all-error: ties keep delay 0.
      force_err = 0;
      const_mode = 1;
      k_dly = 0;
      restart();
      wait_lock(n);
      check("t3_lock_strobes", n, 15 + 16 * 15);
      check("t3_delay", o_delay, 0);
      run_chk(20);
      check("t3_bits", o_counter_bit, 20);
      check("t3_errs", o_counter_err, 20);
      check("t3_sat_bits", s_counter_bit, 15);
      check("t3_sat_errs", s_counter_err, 15);

      // Asynchronous reset in the middle of the search.
      const_mode = 0;
      k_dly = 3;
      restart();
      for (int i = 0; i < 35; i++) strobe(0);
      check("t5_busy_pre", o_busy, 1);
      #2;
      i_reset = 1'b0;
      #1;
      check("t5_busy", o_busy, 0);
      check("t5_locked", o_locked, 0);
      check("t5_delay", o_delay, 0);
      check("t5_exor", o_exor, 0);
      repeat (2) @(posedge clock);
      #1;
      i_reset = 1'b1;
      @(posedge clock); #1;
      check("t5_busy_restart", o_busy, 1);
      wait_lock(n);
      check("t5_lock_strobes", n, 15 + 4 * 15);
      check("t5_relock_delay", o_delay, 3);
      run_chk(5);
      check("t5_bits", o_counter_bit, 5);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
